core_run_ctrl: RTL and testbench
================================

# core_run_ctrl

Run controller for the FPGA core-under-test harness. It sequences the core's reset and fetch enable from a start button and watches the pass/fail/exit signals. A watchdog aborts hung runs. Results are latched into sticky status outputs for the board LEDs. It sits between the board I/O (buttons, LEDs, RGB) and the core testbench wrapper's `rst_ni`/`fetch_enable_i`/result ports, in the `clk_5mhz` domain.

## Interface
Parameters:
- `RST_HOLD_CYCLES`, 16: cycles the core is held in reset before fetch is enabled; legal range ≥1.
- `WDOG_CYCLES`, 5000000: consecutive cycles without `instr_req_i` that count as a hang (1 s at 5 MHz); legal range ≥2.
- `BLINK_HALF`, 2500000: half-period of the running heartbeat, in cycles; legal range ≥1.
- `AUTO_START`, 1: when 1, one run starts automatically after `rst_ni` deasserts.

Ports:
- `clk_5mhz`, in, 1: clock.
- `rst_ni`, in, 1: reset, asynchronous, active-low.
- `start_i`, in, 1: raw start button, asynchronous to the clock.
- `abort_i`, in, 1: synchronous level; returns the block to IDLE.
- `tests_passed_i`, in, 1: pass pulse from the core wrapper.
- `tests_failed_i`, in, 1: fail pulse from the core wrapper.
- `exit_valid_i`, in, 1: exit pulse from the core wrapper.
- `exit_value_i`, in, 32: exit code, qualified by `exit_valid_i`.
- `instr_req_i`, in, 1: core instruction request, used as the activity indicator.
- `core_rst_no`, out, 1: active-low reset to the core wrapper.
- `fetch_enable_o`, out, 1: fetch enable to the core wrapper.
- `state_o`, out, 3: current state encoding.
- `pass_o`, `fail_o`, `timeout_o`, out, 1 each: sticky result flags.
- `exit_code_o`, out, 32: latched exit value.
- `blink_o`, out, 1: status LED drive.

## Operation
- `start_i` passes through a 2-FF synchronizer and then a rising-edge detector. The result is a one-cycle `start_evt`. A held button produces only one event.
- State encodings: IDLE=0, RESET=1, RUN=2, PASS=3, FAIL=4, TIMEOUT=5. Codes 6 and 7 are illegal and go to IDLE on the next cycle.
- **IDLE**
  - Outputs: `core_rst_no`=0, `fetch_enable_o`=0.
  - `start_evt` moves to RESET.
  - With `AUTO_START`=1, the first cycle after reset release moves to RESET unconditionally. This happens once per `rst_ni` assertion.
- **RESET**
  - Outputs: `core_rst_no`=0, `fetch_enable_o`=0.
  - On entry, the hold counter, `pass_o`/`fail_o`/`timeout_o` and `exit_code_o` are cleared.
  - After exactly `RST_HOLD_CYCLES` cycles in RESET, moves to RUN.
- **RUN**
  - Outputs: `core_rst_no`=1, `fetch_enable_o`=1.
  - Exit priority, highest first, when several occur in the same cycle:
    - `tests_failed_i` → FAIL.
    - `tests_passed_i` → PASS.
    - `exit_valid_i` → PASS if `exit_value_i`==0, otherwise FAIL.
    - Watchdog expiry → TIMEOUT.
  - `exit_code_o` captures `exit_value_i` on any cycle where `exit_valid_i`=1 in RUN, including the terminating cycle.
  - `start_evt` is ignored in RUN.
- **PASS / FAIL / TIMEOUT** (terminal states)
  - Outputs: `core_rst_no`=1, so the core state stays inspectable; `fetch_enable_o`=0.
  - The matching sticky flag is set on entry.
  - `start_evt` moves to RESET for a rerun.
  - Inputs from the core are ignored.
- `abort_i`=1 in any state moves to IDLE on the next edge and has priority over every other transition. The sticky flags are kept.
- Watchdog counter:
  - Width is `$clog2(WDOG_CYCLES)`.
  - Cleared on entry to RUN and on every RUN cycle where `instr_req_i`=1; otherwise increments.
  - Expiry is count == `WDOG_CYCLES-1` with `instr_req_i`=0.
  - Saturates and never wraps.
- `blink_o`:
  - RUN: toggles every `BLINK_HALF` cycles, with the counter restarting on RUN entry.
  - PASS: 1.
  - All other states: 0.

## Timing
- All outputs are registered. Reset values:
  - `state_o`=0
  - `core_rst_no`=0
  - `fetch_enable_o`=0
  - `pass_o`=0, `fail_o`=0, `timeout_o`=0
  - `exit_code_o`=0
  - `blink_o`=0
- Start latency: if `start_i` is first sampled high at edge N, `state_o`=1 after edge N+3.
- `core_rst_no` and `fetch_enable_o` rise after the same edge that `state_o` becomes 2.
- Result latency: a pass, fail or exit pulse sampled at edge M gives the new state and flags after edge M. Fetch drops on that same edge.
- Reset mid-run: `rst_ni` low clears everything asynchronously, and the core is held in reset immediately.

## Configuration
- `CORE_RUN_CTRL_WDOG_EN`
  - Defined: the watchdog operates as specified.
  - Undefined: no watchdog counter is built, TIMEOUT is unreachable, and `timeout_o` is tied to 0. RUN ends only on result inputs or `abort_i`.

## Test plan
All scenarios use `RST_HOLD_CYCLES`=4, `WDOG_CYCLES`=100, `BLINK_HALF`=8, `AUTO_START`=0.
- Reset, then raise `start_i` at edge 10:
  - `state_o`=1 after edge 13.
  - `state_o`=2 and `fetch_enable_o`=1 after edge 17.
  - `blink_o` toggles every 8 cycles.
- In RUN, pulse `exit_valid_i` with `exit_value_i`=0x0000002A → `state_o`=4, `fail_o`=1, `exit_code_o`=0x2A, `fetch_enable_o`=0.
- In RUN, pulse `tests_passed_i` and `tests_failed_i` in the same cycle → `state_o`=4, `fail_o`=1, `pass_o`=0.
- In RUN, hold `instr_req_i`=0 → `state_o`=5 and `timeout_o`=1 exactly 100 cycles after RUN entry. With the macro undefined, the block stays in RUN.
- From PASS, press start → RESET with the flags cleared, then RUN 4 cycles later. Asserting `abort_i` in RUN → IDLE with `core_rst_no`=0 on the next edge.
- Assert `rst_ni`=0 mid-run → all outputs return to their reset values without a clock edge.

Source files
------------

// File: rtl/core_run_ctrl.sv
// Run controller for the core-under-test harness: start/reset/fetch sequencing,
// result capture, watchdog and LED heartbeat. Watchdog built only with CORE_RUN_CTRL_WDOG_EN.
module core_run_ctrl #(
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned WDOG_CYCLES     = 5000000,
  parameter int unsigned BLINK_HALF      = 2500000,
  parameter bit          AUTO_START      = 1'b1
) (
  input  logic        clk_5mhz,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic        tests_passed_i,
  input  logic        tests_failed_i,
  input  logic        exit_valid_i,
  input  logic [31:0] exit_value_i,
  input  logic        instr_req_i,
  output logic        core_rst_no,
  output logic        fetch_enable_o,
  output logic [2:0]  state_o,
  output logic        pass_o,
  output logic        fail_o,
  output logic        timeout_o,
  output logic [31:0] exit_code_o,
  output logic        blink_o
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RESET   = 3'd1,
    S_RUN     = 3'd2,
    S_PASS    = 3'd3,
    S_FAIL    = 3'd4,
    S_TIMEOUT = 3'd5
  } state_e;

  localparam int unsigned HOLD_W  = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_HOLD_CYCLES - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

  state_e              state_q, state_d;
  logic                start_s1, start_s2, start_s3, start_evt;
  logic                auto_pend;
  logic [HOLD_W-1:0]   hold_cnt;
  logic [BLINK_W-1:0]  blink_cnt;
  logic                wdog_expire;
  logic                enter_reset, enter_run;

  // Two synchronizer flops, then a registered rising-edge detect so a held
  // button yields exactly one start event.
  // NOTE: sequential state always uses <= so every flop samples pre-edge values;
  // blocking here would collapse the synchronizer chain into a single stage.
  always_ff @(posedge clk_5mhz or negedge rst_ni) begin
    if (!rst_ni) begin
      start_s1  <= 1'b0;
      start_s2  <= 1'b0;
      start_s3  <= 1'b0;
      start_evt <= 1'b0;
      auto_pend <= AUTO_START;
    end else begin
      start_s1  <= start_i;
      start_s2  <= start_s1;
      start_s3  <= start_s2;
      start_evt <= start_s2 & ~start_s3;
      auto_pend <= 1'b0;
    end
  end

  always_ff @(posedge clk_5mhz or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; otherwise always_comb would infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_evt || auto_pend) state_d = S_RESET;
      S_RESET: if (hold_cnt == HOLD_LAST) state_d = S_RUN;
      S_RUN: begin
        if (tests_failed_i)      state_d = S_FAIL;
        else if (tests_passed_i) state_d = S_PASS;
        else if (exit_valid_i)   state_d = (exit_value_i == 32'd0) ? S_PASS : S_FAIL;
        else if (wdog_expire)    state_d = S_TIMEOUT;
      end
      S_PASS, S_FAIL, S_TIMEOUT: if (start_evt) state_d = S_RESET;
      default: state_d = S_IDLE;
    endcase
    if (abort_i) state_d = S_IDLE;
  end

  assign enter_reset = (state_d == S_RESET) && (state_q != S_RESET);
  assign enter_run   = (state_d == S_RUN) && (state_q != S_RUN);
  assign state_o     = state_q;

  always_ff @(posedge clk_5mhz or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_cnt <= '0;
    end else if (enter_reset) begin
      hold_cnt <= '0;
    end else if (state_q == S_RESET) begin
      hold_cnt <= hold_cnt + 1'b1;
    end
  end

`ifdef CORE_RUN_CTRL_WDOG_EN
  localparam int unsigned WDOG_W = $clog2(WDOG_CYCLES);
  localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] wdog_cnt;

  // Saturates at the expiry value so a blocked exit (e.g. abort timing) never wraps.
  always_ff @(posedge clk_5mhz or negedge rst_ni) begin
    if (!rst_ni) begin
      wdog_cnt <= '0;
    end else if (enter_run || (state_q == S_RUN && instr_req_i)) begin
      wdog_cnt <= '0;
    end else if (state_q == S_RUN && wdog_cnt != WDOG_LAST) begin
      wdog_cnt <= wdog_cnt + 1'b1;
    end
  end

  assign wdog_expire = (state_q == S_RUN) && !instr_req_i && (wdog_cnt == WDOG_LAST);

  always_ff @(posedge clk_5mhz or negedge rst_ni) begin
    if (!rst_ni)                                          timeout_o <= 1'b0;
    else if (enter_reset)                                 timeout_o <= 1'b0;
    else if (state_d == S_TIMEOUT && state_q != S_TIMEOUT) timeout_o <= 1'b1;
  end
`else
  logic unused_instr_req;
  localparam int unsigned unused_wdog_cycles = WDOG_CYCLES;

  assign unused_instr_req = instr_req_i;
  assign wdog_expire      = 1'b0;
  assign timeout_o        = 1'b0;
`endif

  always_ff @(posedge clk_5mhz or negedge rst_ni) begin
    if (!rst_ni) begin
      blink_cnt <= '0;
    end else if (enter_run) begin
      blink_cnt <= '0;
    end else if (state_q == S_RUN) begin
      blink_cnt <= (blink_cnt == BLINK_LAST) ? '0 : blink_cnt + 1'b1;
    end
  end

  // Outputs are registered from the next state so they change on the same
  // edge as state_o.
  always_ff @(posedge clk_5mhz or negedge rst_ni) begin
    if (!rst_ni) begin
      core_rst_no    <= 1'b0;
      fetch_enable_o <= 1'b0;
      pass_o         <= 1'b0;
      fail_o         <= 1'b0;
      exit_code_o    <= 32'd0;
      blink_o        <= 1'b0;
    end else begin
      core_rst_no    <= (state_d == S_RUN) || (state_d == S_PASS) ||
                        (state_d == S_FAIL) || (state_d == S_TIMEOUT);
      fetch_enable_o <= (state_d == S_RUN);

      case (state_d)
        S_RUN:   blink_o <= enter_run ? 1'b0 :
                            ((blink_cnt == BLINK_LAST) ? ~blink_o : blink_o);
        S_PASS:  blink_o <= 1'b1;
        default: blink_o <= 1'b0;
      endcase

      if (enter_reset) begin
        pass_o      <= 1'b0;
        fail_o      <= 1'b0;
        exit_code_o <= 32'd0;
      end else begin
        if (state_d == S_PASS && state_q != S_PASS) pass_o <= 1'b1;
        if (state_d == S_FAIL && state_q != S_FAIL) fail_o <= 1'b1;
        if (state_q == S_RUN && exit_valid_i)       exit_code_o <= exit_value_i;
      end
    end
  end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Scoreboard bench for core_run_ctrl: expectations are queued with the edge
// they apply to, then popped and compared after that edge.
module tb_core_run_ctrl;

  typedef struct packed {
    logic [2:0]  state;
    logic        rst_n;
    logic        fetch;
    logic        pass;
    logic        fail;
    logic        tmo;
    logic        blink;
    logic [31:0] code;
  } snap_t;

  typedef struct {
    int    at;
    string name;
    snap_t exp;
  } sb_item_t;

  logic        clk_5mhz = 1'b0;
  logic        rst_ni = 1'b1;
  logic        start_i = 1'b0, abort_i = 1'b0;
  logic        tests_passed_i = 1'b0, tests_failed_i = 1'b0, exit_valid_i = 1'b0;
  logic [31:0] exit_value_i = 32'd0;
  logic        instr_req_i = 1'b0;
  logic        core_rst_no, fetch_enable_o, pass_o, fail_o, timeout_o, blink_o;
  logic [2:0]  state_o;
  logic [31:0] exit_code_o;

  sb_item_t sb[$];
  sb_item_t it;
  snap_t    obs;
  int       edge_n = 0;
  int       n_tests = 0;
  int       n_fail = 0;

  core_run_ctrl #(
    .RST_HOLD_CYCLES(4),
    .WDOG_CYCLES    (100),
    .BLINK_HALF     (8),
    .AUTO_START     (1'b0)
  ) dut (
    .clk_5mhz       (clk_5mhz),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .tests_passed_i (tests_passed_i),
    .tests_failed_i (tests_failed_i),
    .exit_valid_i   (exit_valid_i),
    .exit_value_i   (exit_value_i),
    .instr_req_i    (instr_req_i),
    .core_rst_no    (core_rst_no),
    .fetch_enable_o (fetch_enable_o),
    .state_o        (state_o),
    .pass_o         (pass_o),
    .fail_o         (fail_o),
    .timeout_o      (timeout_o),
    .exit_code_o    (exit_code_o),
    .blink_o        (blink_o)
  );

  always #100 clk_5mhz = ~clk_5mhz;

  initial begin
    #(200 * 5000);
    $display("FAIL global_timeout: simulation did not finish within 5000 cycles");
    $fatal(1, "timeout");
  end

  function automatic snap_t mk(logic [2:0] st, logic r, logic f, logic p, logic fl,
                               logic t, logic b, logic [31:0] c);
    snap_t s;
    s = '{state: st, rst_n: r, fetch: f, pass: p, fail: fl, tmo: t, blink: b, code: c};
    return s;
  endfunction

  function automatic snap_t sample();
    return mk(state_o, core_rst_no, fetch_enable_o, pass_o, fail_o, timeout_o,
              blink_o, exit_code_o);
  endfunction

  task automatic push(input int at, input string name, input snap_t exp);
    sb.push_back('{at: at, name: name, exp: exp});
  endtask

  task automatic tick();
    @(posedge clk_5mhz);
    #1;
    edge_n++;
  endtask

  task automatic wait_edge(input int n);
    while (edge_n < n) tick();
  endtask

  task automatic do_reset();
    {start_i, abort_i, tests_passed_i, tests_failed_i, exit_valid_i} = '0;
    exit_value_i = 32'd0;
    rst_ni = 1'b1;
    #10 rst_ni = 1'b0;
    #400;
    @(negedge clk_5mhz);
    rst_ni = 1'b1;
    edge_n = 0;
  endtask

  // Brings the DUT from a fresh reset into RUN at edge 17 (start sampled at 10).
  task automatic start_to_run(input logic req);
    do_reset();
    instr_req_i = req;
    wait_edge(9);
    start_i = 1'b1;
  endtask

  task automatic test_reset();
    {start_i, abort_i, tests_passed_i, tests_failed_i, exit_valid_i} = '0;
    #10 rst_ni = 1'b0;
    #250;
    push(edge_n, "reset_values", mk(3'd0, 0, 0, 0, 0, 0, 0, 32'd0));
    @(negedge clk_5mhz);
    rst_ni = 1'b1;
    edge_n = 0;
    push(5, "idle_no_autostart", mk(3'd0, 0, 0, 0, 0, 0, 0, 32'd0));
    while (sb.size() != 0) begin
      it = sb.pop_front(); wait_edge(it.at); obs = sample(); n_tests++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got %h, expected %h", it.name, edge_n, obs, it.exp);
      end
    end
  endtask

  task automatic test_start_blink_exit();
    start_to_run(1'b1);
    push(12, "start_latency_idle", mk(3'd0, 0, 0, 0, 0, 0, 0, 32'd0));
    push(13, "start_enter_reset",  mk(3'd1, 0, 0, 0, 0, 0, 0, 32'd0));
    push(16, "reset_hold",         mk(3'd1, 0, 0, 0, 0, 0, 0, 32'd0));
    push(17, "run_entry",          mk(3'd2, 1, 1, 0, 0, 0, 0, 32'd0));
    push(24, "blink_low_before",   mk(3'd2, 1, 1, 0, 0, 0, 0, 32'd0));
    push(25, "blink_first_toggle", mk(3'd2, 1, 1, 0, 0, 0, 1, 32'd0));
    push(32, "blink_high_hold",    mk(3'd2, 1, 1, 0, 0, 0, 1, 32'd0));
    push(33, "blink_second_toggle", mk(3'd2, 1, 1, 0, 0, 0, 0, 32'd0));
    push(40, "held_start_ignored", mk(3'd2, 1, 1, 0, 0, 0, 0, 32'd0));
    while (sb.size() != 0) begin
      it = sb.pop_front(); wait_edge(it.at); obs = sample(); n_tests++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got %h, expected %h", it.name, edge_n, obs, it.exp);
      end
    end
    exit_valid_i = 1'b1;
    exit_value_i = 32'h0000_002A;
    push(41, "exit_nonzero_fail", mk(3'd4, 1, 0, 0, 1, 0, 0, 32'h2A));
    while (sb.size() != 0) begin
      it = sb.pop_front(); wait_edge(it.at); obs = sample(); n_tests++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got %h, expected %h", it.name, edge_n, obs, it.exp);
      end
    end
    exit_valid_i = 1'b0;
    exit_value_i = 32'h0000_0055;
    push(45, "fail_sticky", mk(3'd4, 1, 0, 0, 1, 0, 0, 32'h2A));
    while (sb.size() != 0) begin
      it = sb.pop_front(); wait_edge(it.at); obs = sample(); n_tests++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got %h, expected %h", it.name, edge_n, obs, it.exp);
      end
    end
  endtask

  task automatic test_priority_rerun();
    start_to_run(1'b1);
    wait_edge(19);
    tests_passed_i = 1'b1;
    tests_failed_i = 1'b1;
    push(20, "pass_fail_same_cycle", mk(3'd4, 1, 0, 0, 1, 0, 0, 32'd0));
    while (sb.size() != 0) begin
      it = sb.pop_front(); wait_edge(it.at); obs = sample(); n_tests++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got %h, expected %h", it.name, edge_n, obs, it.exp);
      end
    end
    {tests_passed_i, tests_failed_i, start_i} = '0;
    wait_edge(22);
    start_i = 1'b1;
    push(26, "rerun_from_fail_cleared", mk(3'd1, 0, 0, 0, 0, 0, 0, 32'd0));
    push(30, "rerun_run",               mk(3'd2, 1, 1, 0, 0, 0, 0, 32'd0));
    while (sb.size() != 0) begin
      it = sb.pop_front(); wait_edge(it.at); obs = sample(); n_tests++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got %h, expected %h", it.name, edge_n, obs, it.exp);
      end
    end
    wait_edge(32);
    tests_passed_i = 1'b1;
    push(33, "pass_entry", mk(3'd3, 1, 0, 1, 0, 0, 1, 32'd0));
    while (sb.size() != 0) begin
      it = sb.pop_front(); wait_edge(it.at); obs = sample(); n_tests++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got %h, expected %h", it.name, edge_n, obs, it.exp);
      end
    end
    tests_passed_i = 1'b0;
    tests_failed_i = 1'b1;
    push(35, "pass_ignores_core", mk(3'd3, 1, 0, 1, 0, 0, 1, 32'd0));
    while (sb.size() != 0) begin
      it = sb.pop_front(); wait_edge(it.at); obs = sample(); n_tests++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got %h, expected %h", it.name, edge_n, obs, it.exp);
      end
    end
    tests_failed_i = 1'b0;
  endtask

  // Continues from PASS left by test_priority_rerun.
  task automatic test_rerun_abort();
    start_i = 1'b0;
    wait_edge(37);
    start_i = 1'b1;
    push(41, "rerun_from_pass_cleared", mk(3'd1, 0, 0, 0, 0, 0, 0, 32'd0));
    push(44, "rerun_hold",              mk(3'd1, 0, 0, 0, 0, 0, 0, 32'd0));
    push(45, "rerun_run_4_later",       mk(3'd2, 1, 1, 0, 0, 0, 0, 32'd0));
    while (sb.size() != 0) begin
      it = sb.pop_front(); wait_edge(it.at); obs = sample(); n_tests++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got %h, expected %h", it.name, edge_n, obs, it.exp);
      end
    end
    wait_edge(47);
    abort_i = 1'b1;
    push(48, "abort_in_run", mk(3'd0, 0, 0, 0, 0, 0, 0, 32'd0));
    while (sb.size() != 0) begin
      it = sb.pop_front(); wait_edge(it.at); obs = sample(); n_tests++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got %h, expected %h", it.name, edge_n, obs, it.exp);
      end
    end
    abort_i = 1'b0;
    start_i = 1'b0;
    wait_edge(50);
    start_i = 1'b1;
    push(54, "start_after_abort", mk(3'd1, 0, 0, 0, 0, 0, 0, 32'd0));
    push(58, "run_after_abort",   mk(3'd2, 1, 1, 0, 0, 0, 0, 32'd0));
    while (sb.size() != 0) begin
      it = sb.pop_front(); wait_edge(it.at); obs = sample(); n_tests++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got %h, expected %h", it.name, edge_n, obs, it.exp);
      end
    end
    wait_edge(59);
    exit_valid_i = 1'b1;
    exit_value_i = 32'd0;
    push(60, "exit_zero_pass", mk(3'd3, 1, 0, 1, 0, 0, 1, 32'd0));
    while (sb.size() != 0) begin
      it = sb.pop_front(); wait_edge(it.at); obs = sample(); n_tests++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got %h, expected %h", it.name, edge_n, obs, it.exp);
      end
    end
    exit_valid_i = 1'b0;
    abort_i = 1'b1;
    push(61, "abort_keeps_flags", mk(3'd0, 0, 0, 1, 0, 0, 0, 32'd0));
    while (sb.size() != 0) begin
      it = sb.pop_front(); wait_edge(it.at); obs = sample(); n_tests++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got %h, expected %h", it.name, edge_n, obs, it.exp);
      end
    end
    abort_i = 1'b0;
  endtask

  task automatic test_watchdog();
    start_to_run(1'b0);
    push(116, "wdog_not_yet", mk(3'd2, 1, 1, 0, 0, 0, 0, 32'd0));
`ifdef CORE_RUN_CTRL_WDOG_EN
    push(117, "wdog_expiry",  mk(3'd5, 1, 0, 0, 0, 1, 0, 32'd0));
    push(125, "timeout_held", mk(3'd5, 1, 0, 0, 0, 1, 0, 32'd0));
`else
    push(117, "no_wdog_still_run", mk(3'd2, 1, 1, 0, 0, 0, 0, 32'd0));
    push(125, "no_wdog_blinking",  mk(3'd2, 1, 1, 0, 0, 0, 1, 32'd0));
`endif
    while (sb.size() != 0) begin
      it = sb.pop_front(); wait_edge(it.at); obs = sample(); n_tests++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got %h, expected %h", it.name, edge_n, obs, it.exp);
      end
    end
  endtask

  task automatic test_async_reset();
    start_to_run(1'b1);
    push(20, "run_before_reset", mk(3'd2, 1, 1, 0, 0, 0, 0, 32'd0));
    while (sb.size() != 0) begin
      it = sb.pop_front(); wait_edge(it.at); obs = sample(); n_tests++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got %h, expected %h", it.name, edge_n, obs, it.exp);
      end
    end
    #50 rst_ni = 1'b0;
    #1;
    push(edge_n, "async_reset_mid_run", mk(3'd0, 0, 0, 0, 0, 0, 0, 32'd0));
    while (sb.size() != 0) begin
      it = sb.pop_front(); wait_edge(it.at); obs = sample(); n_tests++;
      if (obs !== it.exp) begin
        n_fail++;
        $display("FAIL %s @edge %0d: got %h, expected %h", it.name, edge_n, obs, it.exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start_blink_exit();
    test_priority_rerun();
    test_rerun_abort();
    test_watchdog();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
